// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: operation codes, state encoding
// and the default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_SLL  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_EXEC  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ALU for every operation except the left shift,
// which the sequencer iterates itself.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  // Result and signed overflow; overflow only meaningful for add/subtract.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_ADD: begin
        result   = a + b;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result   = a - b;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Accepts one ALU request at a time, runs it (iterating left shifts one bit
// per cycle) and registers the result and flags for the display path.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH     = ALU_WIDTH,
  parameter int SHIFT_MAX = 32,
  parameter int CNT_W     = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Req,
  output logic             Ready,
  input  logic [WIDTH-1:0] AA,
  input  logic [WIDTH-1:0] BB,
  input  logic [2:0]       ALU_OP,
  output logic [WIDTH-1:0] F,
  output logic             ZF,
  output logic             OF,
  output logic             Done,
  output logic             Busy
);

  state_t             state;
  state_t             next_state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2:0]         op_reg;
  logic [WIDTH-1:0]   shift_reg;
  logic [WIDTH-1:0]   shifted;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_init;
  logic [WIDTH-1:0]   core_result;
  logic               core_overflow;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a        (a_reg),
    .b        (b_reg),
    .op       (op_reg),
    .result   (core_result),
    .overflow (core_overflow)
  );

  // Shift count is clamped so huge shift amounts still finish in bounded time.
  always_comb begin
    cnt_init = a_reg[CNT_W-1:0];
    if (a_reg >= WIDTH'(SHIFT_MAX)) cnt_init = CNT_W'(SHIFT_MAX);
    shifted = shift_reg << 1;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; requests outside IDLE are simply dropped.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (Req) next_state = ST_EXEC;
      ST_EXEC:  next_state = (op_reg == OP_SLL && cnt_init != '0) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (cnt == CNT_W'(1)) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    Ready = (state == ST_IDLE);
    Busy  = (state != ST_IDLE);
    Done  = (state == ST_DONE);
  end

  // Operand capture, shift iteration and result/flag registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      shift_reg <= '0;
      cnt       <= '0;
      F         <= '0;
      ZF        <= 1'b0;
      OF        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Req) begin
            a_reg  <= AA;
            b_reg  <= BB;
            op_reg <= ALU_OP;
          end
        end
        ST_EXEC: begin
          if (op_reg == OP_SLL) begin
            shift_reg <= b_reg;
            cnt       <= cnt_init;
            if (cnt_init == '0) begin
              F  <= b_reg;
              ZF <= (b_reg == '0);
              OF <= 1'b0;
            end
          end else begin
            F  <= core_result;
            ZF <= (core_result == '0);
            OF <= core_overflow;
          end
        end
        ST_SHIFT: begin
          shift_reg <= shifted;
          cnt       <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            F  <= shifted;
            ZF <= (shifted == '0);
            OF <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
